id_ex_reg: RTL and testbench



---
 rtl/id_ex_reg_pkg.sv | 22 ++
 rtl/id_ex_reg_fwd_mux.sv | 29 ++
 rtl/id_ex_reg.sv | 125 ++++++++++++
 tb/tb_id_ex_reg.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/id_ex_reg_pkg.sv
// rtl/id_ex_reg_pkg.sv - shared opcodes, NOP encoding and state type for id_ex_reg (forwarding enabled by ID_EX_FWD_EN)
package id_ex_reg_pkg;

    localparam logic [6:0]  INST_TYPE_I   = 7'b0010011;
    localparam logic [6:0]  INST_TYPE_R_M = 7'b0110011;
    localparam logic [6:0]  INST_TYPE_B   = 7'b1100011;
    localparam logic [31:0] INST_NOP      = 32'h0000_0013;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_BUBBLE = 1'b1
    } state_e;

    function automatic logic uses_rs1(input logic [6:0] opcode);
        return (opcode == INST_TYPE_I) || (opcode == INST_TYPE_R_M) || (opcode == INST_TYPE_B);
    endfunction

    function automatic logic uses_rs2(input logic [6:0] opcode);
        return (opcode == INST_TYPE_R_M) || (opcode == INST_TYPE_B);
    endfunction

endpackage

// File: rtl/id_ex_reg_fwd_mux.sv
// rtl/id_ex_reg_fwd_mux.sv - EX-result forwarding into captured operands (used only with ID_EX_FWD_EN)
module id_ex_reg_fwd_mux
    import id_ex_reg_pkg::*;
(
    input  logic [6:0]  opcode_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [31:0] op_num1_i,
    input  logic [31:0] op_num2_i,
    input  logic [4:0]  ex_rd_addr_i,
    input  logic [31:0] ex_rd_data_i,
    input  logic        ex_rd_wen_i,
    output logic [31:0] op_num1_o,
    output logic [31:0] op_num2_o
);

    logic ex_live;
    logic fwd1;
    logic fwd2;

    // x0 is never forwarded: writes to it are discarded by the register file
    assign ex_live = ex_rd_wen_i && (ex_rd_addr_i != 5'd0);
    assign fwd1    = ex_live && uses_rs1(opcode_i) && (rs1_i == ex_rd_addr_i);
    assign fwd2    = ex_live && uses_rs2(opcode_i) && (rs2_i == ex_rd_addr_i);

    assign op_num1_o = fwd1 ? ex_rd_data_i : op_num1_i;
    assign op_num2_o = fwd2 ? ex_rd_data_i : op_num2_i;

endmodule

// File: rtl/id_ex_reg.sv
// rtl/id_ex_reg.sv - ID/EX pipeline register with stall, multi-cycle flush bubbles, optional forwarding (ID_EX_FWD_EN)
module id_ex_reg
    import id_ex_reg_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter logic [31:0] NOP_INST     = INST_NOP
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst_i,
    input  logic [31:0] inst_addr_i,
    input  logic [31:0] op_num1_i,
    input  logic [31:0] op_num2_i,
    input  logic [4:0]  rd_addr_i,
    input  logic        rd_wen_i,
    input  logic        stall_i,
    input  logic        flush_i,
`ifdef ID_EX_FWD_EN
    input  logic [4:0]  ex_rd_addr_i,
    input  logic [31:0] ex_rd_data_i,
    input  logic        ex_rd_wen_i,
`endif
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o,
    output logic [31:0] op_num1_o,
    output logic [31:0] op_num2_o,
    output logic [4:0]  rd_addr_o,
    output logic        rd_wen_o,
    output logic        valid_o
);

    localparam logic [1:0] FLUSH_CNT = FLUSH_CYCLES[1:0];

    state_e      state_q;
    logic [1:0]  bub_cnt_q;
    logic [31:0] inst_q;
    logic [31:0] inst_addr_q;
    logic [31:0] op1_q;
    logic [31:0] op2_q;
    logic [4:0]  rd_addr_q;
    logic        rd_wen_q;
    logic        valid_q;

    logic [31:0] op1_d;
    logic [31:0] op2_d;

`ifdef ID_EX_FWD_EN
    id_ex_reg_fwd_mux u_fwd_mux (
        .opcode_i     (inst_i[6:0]),
        .rs1_i        (inst_i[19:15]),
        .rs2_i        (inst_i[24:20]),
        .op_num1_i    (op_num1_i),
        .op_num2_i    (op_num2_i),
        .ex_rd_addr_i (ex_rd_addr_i),
        .ex_rd_data_i (ex_rd_data_i),
        .ex_rd_wen_i  (ex_rd_wen_i),
        .op_num1_o    (op1_d),
        .op_num2_o    (op2_d)
    );
`else
    assign op1_d = op_num1_i;
    assign op2_d = op_num2_i;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_RUN;
            bub_cnt_q   <= 2'd0;
            inst_q      <= NOP_INST;
            inst_addr_q <= 32'd0;
            op1_q       <= 32'd0;
            op2_q       <= 32'd0;
            rd_addr_q   <= 5'd0;
            rd_wen_q    <= 1'b0;
            valid_q     <= 1'b0;
        end else if (flush_i) begin
            inst_q      <= NOP_INST;
            inst_addr_q <= 32'd0;
            op1_q       <= 32'd0;
            op2_q       <= 32'd0;
            rd_addr_q   <= 5'd0;
            rd_wen_q    <= 1'b0;
            valid_q     <= 1'b0;
            if (FLUSH_CYCLES > 0) begin
                state_q   <= ST_BUBBLE;
                bub_cnt_q <= FLUSH_CNT;
            end else begin
                state_q   <= ST_RUN;
                bub_cnt_q <= 2'd0;
            end
        end else if (stall_i) begin
            state_q <= state_q;
        end else if (state_q == ST_BUBBLE) begin
            inst_q      <= NOP_INST;
            inst_addr_q <= 32'd0;
            op1_q       <= 32'd0;
            op2_q       <= 32'd0;
            rd_addr_q   <= 5'd0;
            rd_wen_q    <= 1'b0;
            valid_q     <= 1'b0;
            bub_cnt_q   <= bub_cnt_q - 2'd1;
            // the 1 -> 0 step is the final bubble
            if (bub_cnt_q <= 2'd1) begin
                state_q <= ST_RUN;
            end
        end else begin
            inst_q      <= inst_i;
            inst_addr_q <= inst_addr_i;
            op1_q       <= op1_d;
            op2_q       <= op2_d;
            rd_addr_q   <= rd_addr_i;
            rd_wen_q    <= rd_wen_i && (rd_addr_i != 5'd0);
            valid_q     <= 1'b1;
        end
    end

    assign inst_o      = inst_q;
    assign inst_addr_o = inst_addr_q;
    assign op_num1_o   = op1_q;
    assign op_num2_o   = op2_q;
    assign rd_addr_o   = rd_addr_q;
    assign rd_wen_o    = rd_wen_q;
    assign valid_o     = valid_q;

endmodule

// File: tb/tb_id_ex_reg.sv
// tb/tb_id_ex_reg.sv - directed table-driven bench for id_ex_reg (FLUSH_CYCLES = 1; forwarding cases with ID_EX_FWD_EN)
module tb_id_ex_reg;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] addr;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [4:0]  rd;
        logic        wen;
        logic        stall;
        logic        flush;
        logic [31:0] e_inst;
        logic [31:0] e_addr;
        logic [31:0] e_op1;
        logic [31:0] e_op2;
        logic [4:0]  e_rd;
        logic        e_wen;
        logic        e_valid;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] inst_i = '0;
    logic [31:0] inst_addr_i = '0;
    logic [31:0] op_num1_i = '0;
    logic [31:0] op_num2_i = '0;
    logic [4:0]  rd_addr_i = '0;
    logic        rd_wen_i = 1'b0;
    logic        stall_i = 1'b0;
    logic        flush_i = 1'b0;
`ifdef ID_EX_FWD_EN
    logic [4:0]  ex_rd_addr_i = '0;
    logic [31:0] ex_rd_data_i = '0;
    logic        ex_rd_wen_i = 1'b0;
`endif
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;
    logic [31:0] op_num1_o;
    logic [31:0] op_num2_o;
    logic [4:0]  rd_addr_o;
    logic        rd_wen_o;
    logic        valid_o;

    int n_tests = 0;
    int n_fail  = 0;
    vec_t vecs[18];

    always #5 clk = ~clk;

    id_ex_reg #(.FLUSH_CYCLES(1), .NOP_INST(NOP)) dut (
        .clk          (clk),
        .rst          (rst),
        .inst_i       (inst_i),
        .inst_addr_i  (inst_addr_i),
        .op_num1_i    (op_num1_i),
        .op_num2_i    (op_num2_i),
        .rd_addr_i    (rd_addr_i),
        .rd_wen_i     (rd_wen_i),
        .stall_i      (stall_i),
        .flush_i      (flush_i),
`ifdef ID_EX_FWD_EN
        .ex_rd_addr_i (ex_rd_addr_i),
        .ex_rd_data_i (ex_rd_data_i),
        .ex_rd_wen_i  (ex_rd_wen_i),
`endif
        .inst_o       (inst_o),
        .inst_addr_o  (inst_addr_o),
        .op_num1_o    (op_num1_o),
        .op_num2_o    (op_num2_o),
        .rd_addr_o    (rd_addr_o),
        .rd_wen_o     (rd_wen_o),
        .valid_o      (valid_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input vec_t v);
        chk({tag, " inst_o"},      inst_o,      v.e_inst);
        chk({tag, " inst_addr_o"}, inst_addr_o, v.e_addr);
        chk({tag, " op_num1_o"},   op_num1_o,   v.e_op1);
        chk({tag, " op_num2_o"},   op_num2_o,   v.e_op2);
        chk({tag, " rd_addr_o"},   {27'd0, rd_addr_o}, {27'd0, v.e_rd});
        chk({tag, " rd_wen_o"},    {31'd0, rd_wen_o},  {31'd0, v.e_wen});
        chk({tag, " valid_o"},     {31'd0, valid_o},   {31'd0, v.e_valid});
    endtask

    task automatic step(input string tag, input vec_t v);
        inst_i      = v.inst;
        inst_addr_i = v.addr;
        op_num1_i   = v.op1;
        op_num2_i   = v.op2;
        rd_addr_i   = v.rd;
        rd_wen_i    = v.wen;
        stall_i     = v.stall;
        flush_i     = v.flush;
        @(posedge clk);
        #1;
        chk_outs(tag, v);
    endtask

    task automatic async_reset_check(input string tag);
        vec_t r;
        r = '{32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0,
              NOP, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0};
        #2 rst = 1'b1;
        #1 chk_outs(tag, r);
        #2 rst = 1'b0;
    endtask

    initial begin
        vec_t rv;
        vec_t x;
        // {inst, addr, op1, op2, rd, wen, stall, flush, exp inst, addr, op1, op2, rd, wen, valid}
        vecs[0]  = '{32'h0010_0093, 32'h100, 0, 1, 1, 1, 0, 0,   32'h0010_0093, 32'h100, 0, 1, 1, 1, 1};
        vecs[1]  = '{32'h0020_81b3, 32'h104, 5, 7, 3, 1, 0, 0,   32'h0020_81b3, 32'h104, 5, 7, 3, 1, 1};
        vecs[2]  = '{32'h0050_0013, 32'h108, 9, 5, 0, 1, 0, 0,   32'h0050_0013, 32'h108, 9, 5, 0, 0, 1};
        vecs[3]  = '{32'h1111_1111, 32'h10c, 1, 2, 6, 1, 1, 0,   32'h0050_0013, 32'h108, 9, 5, 0, 0, 1};
        vecs[4]  = '{32'hdead_beef, 32'h999, 1, 2, 7, 1, 0, 1,   NOP, 0, 0, 0, 0, 0, 0};
        vecs[5]  = '{32'h00a0_0113, 32'h200, 0, 10, 2, 1, 0, 0,  NOP, 0, 0, 0, 0, 0, 0};
        vecs[6]  = '{32'h00a0_0113, 32'h200, 0, 10, 2, 1, 0, 0,  32'h00a0_0113, 32'h200, 0, 10, 2, 1, 1};
        vecs[7]  = '{32'hdead_beef, 32'h999, 1, 2, 7, 1, 0, 1,   NOP, 0, 0, 0, 0, 0, 0};
        vecs[8]  = '{32'h0020_81b3, 32'h300, 3, 4, 3, 1, 1, 0,   NOP, 0, 0, 0, 0, 0, 0};
        vecs[9]  = '{32'h0020_81b3, 32'h300, 3, 4, 3, 1, 1, 0,   NOP, 0, 0, 0, 0, 0, 0};
        vecs[10] = '{32'h0020_81b3, 32'h300, 3, 4, 3, 1, 1, 0,   NOP, 0, 0, 0, 0, 0, 0};
        vecs[11] = '{32'h0020_81b3, 32'h300, 3, 4, 3, 1, 0, 0,   NOP, 0, 0, 0, 0, 0, 0};
        vecs[12] = '{32'h0020_81b3, 32'h300, 3, 4, 3, 1, 0, 0,   32'h0020_81b3, 32'h300, 3, 4, 3, 1, 1};
        vecs[13] = '{32'hdead_beef, 32'h999, 1, 2, 7, 1, 1, 1,   NOP, 0, 0, 0, 0, 0, 0};
        vecs[14] = '{32'hdead_beef, 32'h999, 1, 2, 7, 1, 0, 1,   NOP, 0, 0, 0, 0, 0, 0};
        vecs[15] = '{32'h4020_8233, 32'h400, 8, 2, 4, 1, 0, 0,   NOP, 0, 0, 0, 0, 0, 0};
        vecs[16] = '{32'h4020_8233, 32'h400, 8, 2, 4, 1, 0, 0,   32'h4020_8233, 32'h400, 8, 2, 4, 1, 1};
        vecs[17] = '{32'h0000_0000, 32'h404, 1, 1, 5, 1, 1, 0,   32'h4020_8233, 32'h400, 8, 2, 4, 1, 1};

        #1 rst = 1'b1;
        #1;
        rv = '{32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0,
               NOP, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0};
        chk_outs("reset", rv);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 18; i++) begin
            step($sformatf("vec%0d", i), vecs[i]);
        end

        // asynchronous reset while holding a real instruction, then mid-bubble
        async_reset_check("arst_run");
        step("arst_flush", vecs[4]);
        async_reset_check("arst_bub");
        x = '{32'h0030_0193, 32'h500, 0, 3, 3, 1, 0, 0, 32'h0030_0193, 32'h500, 0, 3, 3, 1, 1};
        step("post_arst_load", x);

`ifdef ID_EX_FWD_EN
        ex_rd_addr_i = 5'd1;
        ex_rd_data_i = 32'h0000_00AA;
        ex_rd_wen_i  = 1'b1;
        x = '{32'h0020_81b3, 32'h600, 5, 7, 3, 1, 0, 0, 32'h0020_81b3, 32'h600, 32'hAA, 7, 3, 1, 1};
        step("fwd_rs1", x);
        ex_rd_addr_i = 5'd2;
        x = '{32'h0020_81b3, 32'h604, 5, 7, 3, 1, 0, 0, 32'h0020_81b3, 32'h604, 5, 32'hAA, 3, 1, 1};
        step("fwd_rs2", x);
        ex_rd_addr_i = 5'd0;
        x = '{32'h0020_81b3, 32'h608, 5, 7, 3, 1, 0, 0, 32'h0020_81b3, 32'h608, 5, 7, 3, 1, 1};
        step("fwd_x0", x);
        ex_rd_addr_i = 5'd2;
        x = '{32'h0020_0093, 32'h60c, 5, 7, 1, 1, 0, 0, 32'h0020_0093, 32'h60c, 5, 7, 1, 1, 1};
        step("fwd_itype_rs2", x);
        ex_rd_wen_i = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
